// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - memory stage: load/store unit over req/ready bus, drives MEM/WB register
module mem_stage_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
    input  logic [DATA_WIDTH-1:0] MEM_rs2_data_i,
    input  logic [4:0]            MEM_rd_add_i,
    input  logic                  MEM_regwrite_i,
    input  logic [1:0]            MEM_sel_to_reg_i,
    input  logic                  MEM_RD_mem_i,
    input  logic                  MEM_WR_mem_i,
    input  logic [3:0]            MEM_mem_op_i,
    input  logic [DATA_WIDTH-1:0] MEM_pc_i,
    output logic                  dmem_req_o,
    output logic                  dmem_we_o,
    output logic [DATA_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [3:0]            dmem_be_o,
    input  logic                  dmem_ready_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  mem_stall_o,
    output logic [4:0]            WB_rd_add_o,
    output logic                  WB_regwrite_o,
    output logic [1:0]            WB_sel_to_reg_o,
    output logic [DATA_WIDTH-1:0] WB_alu_result_o,
    output logic [DATA_WIDTH-1:0] WB_load_data_o,
    output logic [DATA_WIDTH-1:0] WB_pc_plus4_o,
    output logic                  misaligned_o,
    output logic                  bus_err_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic       access, store, legal, misalign, valid_acc;
    logic       complete, abort;
    logic [1:0] off, size;
    logic [7:0] rbyte;
    logic [15:0] rhalf;
    logic [31:0] load_ext;

    assign access = MEM_RD_mem_i | MEM_WR_mem_i;
    assign store  = MEM_WR_mem_i;
    assign off    = MEM_alu_result_i[1:0];
    assign size   = MEM_mem_op_i[1:0];

    // Legality is checked against the direction actually performed (store wins).
    always_comb begin
        legal = 1'b0;
        if (store) begin
            legal = (MEM_mem_op_i == 4'd8) || (MEM_mem_op_i == 4'd9) || (MEM_mem_op_i == 4'd10);
        end else begin
            legal = (MEM_mem_op_i == 4'd0) || (MEM_mem_op_i == 4'd1) || (MEM_mem_op_i == 4'd2) ||
                    (MEM_mem_op_i == 4'd4) || (MEM_mem_op_i == 4'd5);
        end
    end

    assign misalign  = access & (~legal | ((size == 2'd1) & off[0]) | ((size == 2'd2) & (off != 2'd0)));
    assign valid_acc = access & ~misalign;
    assign complete  = valid_acc & dmem_ready_i;
    assign abort     = (state == S_WAIT) & valid_acc & ~dmem_ready_i &
                       (TIMEOUT != 0) & (cnt == CNT_W'(TIMEOUT));

    // Bus side is purely combinational; reset gates the request and stall immediately.
    assign dmem_req_o  = rst_n & valid_acc & ((state == S_IDLE) | (state == S_WAIT));
    assign dmem_we_o   = store;
    assign dmem_addr_o = {MEM_alu_result_i[31:2], 2'b00};
    assign mem_stall_o = rst_n & valid_acc & ~dmem_ready_i & ~abort;

    always_comb begin
        dmem_wdata_o = MEM_rs2_data_i;
        dmem_be_o    = 4'b1111;
        case (size)
            2'd0: begin
                dmem_wdata_o = {4{MEM_rs2_data_i[7:0]}};
                dmem_be_o    = 4'b0001 << off;
            end
            2'd1: begin
                dmem_wdata_o = {2{MEM_rs2_data_i[15:0]}};
                dmem_be_o    = 4'b0011 << off;
            end
            default: begin
                dmem_wdata_o = MEM_rs2_data_i;
                dmem_be_o    = 4'b1111;
            end
        endcase
        if (!store) begin
            dmem_be_o = 4'b1111;
        end
    end

    always_comb begin
        rbyte    = dmem_rdata_i[{off, 3'b000} +: 8];
        rhalf    = off[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        load_ext = dmem_rdata_i;
        case (size)
            2'd0:    load_ext = MEM_mem_op_i[2] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'd1:    load_ext = MEM_mem_op_i[2] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            S_IDLE: begin
                if (valid_acc && !dmem_ready_i) begin
                    state_n = S_WAIT;
                    cnt_n   = CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!valid_acc || dmem_ready_i || abort) begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Anything that is neither a finished access nor a non-memory op becomes a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_rd_add_o     <= '0;
            WB_regwrite_o   <= 1'b0;
            WB_sel_to_reg_o <= '0;
            WB_alu_result_o <= '0;
            WB_load_data_o  <= '0;
            WB_pc_plus4_o   <= '0;
            misaligned_o    <= 1'b0;
            bus_err_o       <= 1'b0;
        end else begin
            misaligned_o <= misalign;
            bus_err_o    <= abort;
            if (!access || complete) begin
                WB_rd_add_o     <= MEM_rd_add_i;
                WB_regwrite_o   <= MEM_regwrite_i & ~store;
                WB_sel_to_reg_o <= MEM_sel_to_reg_i;
                WB_alu_result_o <= MEM_alu_result_i;
                WB_load_data_o  <= (access && !store) ? load_ext : '0;
                WB_pc_plus4_o   <= MEM_pc_i + DATA_WIDTH'(4);
            end else begin
                WB_rd_add_o     <= '0;
                WB_regwrite_o   <= 1'b0;
                WB_sel_to_reg_o <= '0;
                WB_alu_result_o <= '0;
                WB_load_data_o  <= '0;
                WB_pc_plus4_o   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - self-checking bench for mem_stage_lsu
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk, rst_n;
    logic [31:0] alu, rs2, pc, rdata;
    logic [4:0]  rd_add;
    logic        regwrite, rdm, wrm, ready;
    logic [1:0]  sel;
    logic [3:0]  op;
    logic        req, we, stall, wb_rw, mis_o, berr;
    logic [31:0] addr_o, wdata, wb_alu, wb_ld, wb_pc4;
    logic [3:0]  be;
    logic [4:0]  wb_rd;
    logic [1:0]  wb_sel;

    int n_chk = 0;
    int n_fail = 0;

    mem_stage_lsu #(.DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .MEM_alu_result_i(alu), .MEM_rs2_data_i(rs2), .MEM_rd_add_i(rd_add),
        .MEM_regwrite_i(regwrite), .MEM_sel_to_reg_i(sel), .MEM_RD_mem_i(rdm),
        .MEM_WR_mem_i(wrm), .MEM_mem_op_i(op), .MEM_pc_i(pc),
        .dmem_req_o(req), .dmem_we_o(we), .dmem_addr_o(addr_o), .dmem_wdata_o(wdata),
        .dmem_be_o(be), .dmem_ready_i(ready), .dmem_rdata_i(rdata), .mem_stall_o(stall),
        .WB_rd_add_o(wb_rd), .WB_regwrite_o(wb_rw), .WB_sel_to_reg_o(wb_sel),
        .WB_alu_result_o(wb_alu), .WB_load_data_o(wb_ld), .WB_pc_plus4_o(wb_pc4),
        .misaligned_o(mis_o), .bus_err_o(berr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rdm, wrm;
        logic [3:0]  op;
        logic [31:0] addr, rs2, rdata, pc;
        logic [4:0]  rdd;
        logic        rw;
        logic [1:0]  sel;
        logic        e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_mis, e_rw;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic addv(input logic a_rd, a_wr, input logic [3:0] a_op,
                        input logic [31:0] a_addr, a_rs2, a_rdata, a_pc,
                        input logic [4:0] a_rdd, input logic a_rw, input logic [1:0] a_sel,
                        input logic e_req, e_we, input logic [3:0] e_be, input logic [31:0] e_wdata,
                        input logic e_mis, e_rw, input logic [31:0] e_ld);
        vec_t v;
        v.rdm = a_rd; v.wrm = a_wr; v.op = a_op; v.addr = a_addr; v.rs2 = a_rs2;
        v.rdata = a_rdata; v.pc = a_pc; v.rdd = a_rdd; v.rw = a_rw; v.sel = a_sel;
        v.e_req = e_req; v.e_we = e_we; v.e_be = e_be; v.e_wdata = e_wdata;
        v.e_mis = e_mis; v.e_rw = e_rw; v.e_ld = e_ld;
        vq.push_back(v);
    endtask

    task automatic drive(input logic a_rd, a_wr, input logic [3:0] a_op,
                         input logic [31:0] a_addr, a_rs2, a_rdata, a_pc,
                         input logic [4:0] a_rdd, input logic a_rw, input logic [1:0] a_sel);
        rdm = a_rd; wrm = a_wr; op = a_op; alu = a_addr; rs2 = a_rs2;
        rdata = a_rdata; pc = a_pc; rd_add = a_rdd; regwrite = a_rw; sel = a_sel;
    endtask

    // Reference: loaded value from the word, by byte offset, width and signedness.
    function automatic logic [31:0] model_load(input logic [3:0] m_op, input logic [31:0] m_addr,
                                               input logic [31:0] m_rdata);
        int          nb;
        logic [63:0] v;
        nb = 1 << (m_op % 4);
        if (nb >= 4) return m_rdata;
        v = ({32'd0, m_rdata} >> (8 * (m_addr % 4))) & ((64'd1 << (8 * nb)) - 64'd1);
        if (m_op < 4 && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v - (64'd1 << (8 * nb));
        return v[31:0];
    endfunction

    task automatic run_acc(input logic a_rd, a_wr, input logic [3:0] a_op,
                           input logic [31:0] a_addr, a_rs2, a_rdata, a_pc,
                           input logic [4:0] a_rdd, input logic a_rw, input logic [1:0] a_sel,
                           input int lat);
        bit acc, st, legal, m, ab, ok;
        int nb, nst;
        logic [31:0] e_be, e_wd, e_ld;
        acc = a_rd | a_wr;
        st  = a_wr;
        nb  = 1 << (a_op % 4);
        legal = st ? (a_op == 8 || a_op == 9 || a_op == 10)
                   : (a_op == 0 || a_op == 1 || a_op == 2 || a_op == 4 || a_op == 5);
        m   = acc && (!legal || (a_addr % nb) != 0);
        nst = (acc && !m) ? ((lat > TO) ? TO : lat) : 0;
        ab  = acc && !m && (lat > TO);
        ok  = !m && !ab;
        e_be = st ? ((((1 << nb) - 1) << (a_addr % 4)) & 32'hF) : 32'hF;
        e_wd = (nb == 1) ? (a_rs2 & 32'hFF) * 32'h01010101 :
               (nb == 2) ? (a_rs2 & 32'hFFFF) * 32'h00010001 : a_rs2;
        e_ld = (ok && acc && !st) ? model_load(a_op, a_addr, a_rdata) : 32'd0;
        drive(a_rd, a_wr, a_op, a_addr, a_rs2, a_rdata, a_pc, a_rdd, a_rw, a_sel);
        for (int k = 0; k <= nst; k++) begin
            ready = (k == lat);
            @(negedge clk);
            chk($sformatf("acc_stall_c%0d", k), {31'd0, stall}, {31'd0, k < nst});
            if (k == 0) begin
                chk("acc_req", {31'd0, req}, {31'd0, acc && !m});
                if (acc && !m) begin
                    chk("acc_we", {31'd0, we}, {31'd0, st});
                    chk("acc_addr", addr_o, a_addr & ~32'd3);
                    chk("acc_be", {28'd0, be}, e_be);
                    if (st) chk("acc_wdata", wdata, e_wd);
                end
            end
            @(posedge clk); #1;
            if (k < nst) chk($sformatf("acc_bubble_c%0d", k), {31'd0, wb_rw}, 32'd0);
        end
        ready = 1'b0;
        chk("acc_wb_rw", {31'd0, wb_rw}, {31'd0, ok && a_rw && !st});
        chk("acc_wb_ld", wb_ld, e_ld);
        chk("acc_mis", {31'd0, mis_o}, {31'd0, m});
        chk("acc_berr", {31'd0, berr}, {31'd0, ab});
        chk("acc_wb_rd", {27'd0, wb_rd}, ok ? {27'd0, a_rdd} : 32'd0);
        chk("acc_wb_pc4", wb_pc4, ok ? a_pc + 32'd4 : 32'd0);
        chk("acc_wb_alu", wb_alu, ok ? a_addr : 32'd0);
    endtask

    int lops[5] = '{0, 1, 2, 4, 5};
    int sops[3] = '{8, 9, 10};
    int iops[8] = '{3, 6, 7, 11, 12, 13, 14, 15};

    initial begin
        vec_t v;
        logic [31:0] r_addr;
        logic [3:0]  r_op;
        logic        r_rd, r_wr;
        int          kind;

        rst_n = 1'b0; ready = 1'b0;
        drive(1'b1, 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, 32'h2000, 5'd1, 1'b1, 2'd1);
        #22;
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_rw", {31'd0, wb_rw}, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_sel", {30'd0, wb_sel}, 32'd0);
        chk("rst_wb_alu", wb_alu, 32'd0);
        chk("rst_wb_ld", wb_ld, 32'd0);
        chk("rst_wb_pc4", wb_pc4, 32'd0);
        chk("rst_mis", {31'd0, mis_o}, 32'd0);
        chk("rst_berr", {31'd0, berr}, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        addv(0,1,4'd10,32'h100,32'hDEADBEEF,32'h0,32'h1000,5'd3,1,2'd0, 1,1,4'hF,32'hDEADBEEF,0,0,32'h0);
        addv(0,1,4'd8,32'h103,32'h000000A5,32'h0,32'h1004,5'd4,1,2'd0, 1,1,4'h8,32'hA5A5A5A5,0,0,32'h0);
        addv(1,0,4'd0,32'h103,32'h0,32'h80FF0000,32'h1008,5'd5,1,2'd1, 1,0,4'hF,32'h0,0,1,32'hFFFFFF80);
        addv(1,0,4'd4,32'h103,32'h0,32'h80FF0000,32'h100C,5'd6,1,2'd1, 1,0,4'hF,32'h0,0,1,32'h00000080);
        addv(1,0,4'd2,32'h101,32'h0,32'h12345678,32'h1010,5'd7,1,2'd1, 0,0,4'hF,32'h0,1,0,32'h0);
        addv(1,0,4'd3,32'h100,32'h0,32'h12345678,32'h1014,5'd8,1,2'd1, 0,0,4'hF,32'h0,1,0,32'h0);
        addv(0,0,4'd0,32'hCAFE0001,32'h0,32'h0,32'hFFFFFFFC,5'd9,1,2'd2, 0,0,4'hF,32'h0,0,1,32'h0);
        addv(0,1,4'd9,32'h102,32'h1234BEEF,32'h0,32'h1018,5'd10,0,2'd0, 1,1,4'hC,32'hBEEFBEEF,0,0,32'h0);
        addv(1,0,4'd5,32'h202,32'h0,32'h80011234,32'h101C,5'd11,1,2'd1, 1,0,4'hF,32'h0,0,1,32'h00008001);
        addv(1,0,4'd1,32'h200,32'h0,32'h00017FFF,32'h1020,5'd12,1,2'd1, 1,0,4'hF,32'h0,0,1,32'h00007FFF);
        addv(0,1,4'd9,32'h101,32'h55,32'h0,32'h1024,5'd13,0,2'd0, 0,0,4'hF,32'h0,1,0,32'h0);
        addv(1,1,4'd10,32'h10,32'h11223344,32'hFFFFFFFF,32'h1028,5'd14,1,2'd0, 1,1,4'hF,32'h11223344,0,0,32'h0);
        addv(1,0,4'd0,32'h101,32'h0,32'h00008000,32'h102C,5'd15,1,2'd1, 1,0,4'hF,32'h0,0,1,32'hFFFFFF80);
        addv(1,0,4'd2,32'h204,32'h0,32'hA5A55A5A,32'h1030,5'd16,1,2'd3, 1,0,4'hF,32'h0,0,1,32'hA5A55A5A);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            drive(v.rdm, v.wrm, v.op, v.addr, v.rs2, v.rdata, v.pc, v.rdd, v.rw, v.sel);
            ready = 1'b1;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {31'd0, req}, {31'd0, v.e_req});
            chk($sformatf("v%0d_stall", i), {31'd0, stall}, 32'd0);
            if (v.e_req) begin
                chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, v.e_we});
                chk($sformatf("v%0d_addr", i), addr_o, {v.addr[31:2], 2'b00});
                chk($sformatf("v%0d_be", i), {28'd0, be}, {28'd0, v.e_be});
                if (v.e_we) chk($sformatf("v%0d_wdata", i), wdata, v.e_wdata);
            end
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_rw", i), {31'd0, wb_rw}, {31'd0, v.e_rw});
            chk($sformatf("v%0d_wb_ld", i), wb_ld, v.e_ld);
            chk($sformatf("v%0d_mis", i), {31'd0, mis_o}, {31'd0, v.e_mis});
            chk($sformatf("v%0d_berr", i), {31'd0, berr}, 32'd0);
            chk($sformatf("v%0d_wb_rd", i), {27'd0, wb_rd}, v.e_mis ? 32'd0 : {27'd0, v.rdd});
            chk($sformatf("v%0d_wb_sel", i), {30'd0, wb_sel}, v.e_mis ? 32'd0 : {30'd0, v.sel});
            chk($sformatf("v%0d_wb_alu", i), wb_alu, v.e_mis ? 32'd0 : v.addr);
            chk($sformatf("v%0d_wb_pc4", i), wb_pc4, v.e_mis ? 32'd0 : v.pc + 32'd4);
        end
        ready = 1'b0;

        run_acc(1'b1, 1'b0, 4'd1, 32'h202, 32'h0, 32'h80011234, 32'h3000, 5'd7, 1'b1, 2'd1, 3);
        chk("lh_delayed_ld", wb_ld, 32'hFFFF8001);
        chk("lh_delayed_rd", {27'd0, wb_rd}, 32'd7);

        run_acc(1'b1, 1'b0, 4'd2, 32'h300, 32'h0, 32'h0, 32'h3004, 5'd8, 1'b1, 2'd1, 50);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h3008, 5'd2, 1'b1, 2'd0);
        @(negedge clk);
        chk("after_abort_req", {31'd0, req}, 32'd0);
        @(posedge clk); #1;
        chk("berr_one_cycle", {31'd0, berr}, 32'd0);
        chk("after_abort_rw", {31'd0, wb_rw}, 32'd1);

        drive(1'b1, 1'b0, 4'd2, 32'h40, 32'h0, 32'h0, 32'h4000, 5'd9, 1'b1, 2'd1);
        ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        chk("wait_stall", {31'd0, stall}, 32'd1);
        chk("wait_req", {31'd0, req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req", {31'd0, req}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        chk("midrst_wb_pc4", wb_pc4, 32'd0);
        chk("midrst_wb_rw", {31'd0, wb_rw}, 32'd0);
        drive(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_acc(1'b1, 1'b0, 4'd2, 32'h44, 32'h0, 32'h0, 32'h4004, 5'd10, 1'b1, 2'd1, 6);

        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 3);
            r_rd = 1'b0; r_wr = 1'b0; r_op = 4'($urandom_range(0, 15));
            case (kind)
                1: begin r_rd = 1'b1; r_op = 4'(lops[$urandom_range(0, 4)]); end
                2: begin r_wr = 1'b1; r_rd = 1'($urandom_range(0, 1)); r_op = 4'(sops[$urandom_range(0, 2)]); end
                3: begin r_rd = 1'b1; r_op = 4'(iops[$urandom_range(0, 7)]); end
                default: ;
            endcase
            r_addr = $urandom;
            if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
            run_acc(r_rd, r_wr, r_op, r_addr, $urandom, $urandom, $urandom, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
